// File: rtl/ysyx_220053_imem_responder.sv
// Instruction-memory responder for the IFU fetch port: one outstanding request,
// fixed programmable latency, word array mapped at BASE_ADDR with a side load port.
module ysyx_220053_imem_responder #(
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          MEM_WORDS = 4096,
   parameter int          LATENCY   = 2,
   localparam int         IDX_W     = $clog2(MEM_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [63:0]      req_addr,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic             resp_err,
   input  logic             ld_en,
   input  logic [IDX_W-1:0] ld_idx,
   input  logic [31:0]      ld_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [63:0] SPAN     = 64'(MEM_WORDS) << 2;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             rdy_q;
   logic [31:0]      data_q;
   logic             err_q;
   logic [31:0]      mem [MEM_WORDS];

   logic [63:0]      off;
   logic             addr_err;
   logic [IDX_W-1:0] rd_idx;
   logic             accept;

   // Range check on the full 64-bit address so high addresses cannot wrap into the window.
   assign off      = req_addr - BASE_ADDR;
   assign addr_err = (|req_addr[1:0]) | (req_addr < BASE_ADDR) | (off >= SPAN);
   assign rd_idx   = off[IDX_W+1:2];
   assign accept   = req_valid & rdy_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
               cnt_d   = 4'd0;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // req_ready is registered so it stays low while reset is held and rises one cycle after release.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdy_q   <= (state_d == S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_idx] <= ld_data;
      end
   end

   // Registered read at acceptance; a same-edge load is seen only by later requests.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q <= 32'd0;
         err_q  <= 1'b0;
      end else if (accept) begin
         data_q <= mem[rd_idx];
         err_q  <= addr_err;
      end
   end

   assign req_ready  = rdy_q;
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = err_q;
   assign resp_data  = err_q ? 32'd0 : data_q;

endmodule

// File: tb/tb_ysyx_220053_imem_responder.sv
// Self-checking bench for the imem responder: directed vector table, hand-written
// reset/handshake sequences and randomized fetches against a behavioural memory model.
module tb_ysyx_220053_imem_responder;

   localparam logic [63:0] BASE = 64'h8000_0000;
   localparam int          MW   = 4096;
   localparam int          LAT  = 2;
   localparam int          IW   = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [63:0]   req_addr;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_data;
   logic          resp_err;
   logic          ld_en;
   logic [IW-1:0] ld_idx;
   logic [31:0]   ld_data;

   int            n_chk  = 0;
   int            n_fail = 0;
   logic [31:0]   mdl [MW];

   typedef struct {
      logic [63:0] addr;
      logic [31:0] d;
      logic        e;
      int          hold;
   } vec_t;

   vec_t vecs [10];

   ysyx_220053_imem_responder #(
      .BASE_ADDR (BASE),
      .MEM_WORDS (MW),
      .LATENCY   (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .ld_en      (ld_en),
      .ld_idx     (ld_idx),
      .ld_data    (ld_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: an address is good only if word-aligned and inside [BASE, BASE+4*MW).
   function automatic void ref_fetch(input logic [63:0] a, output logic [31:0] d, output logic e);
      logic [64:0] a65 = {1'b0, a};
      logic [64:0] lo  = {1'b0, BASE};
      logic [64:0] hi  = lo + 65'(MW) * 65'd4;
      e = (a % 64'd4 != 64'd0) || (a65 < lo) || (a65 >= hi);
      d = 32'd0;
      if (!e) d = mdl[int'((a - BASE) >> 2)];
   endfunction

   task automatic load(input logic [IW-1:0] i, input logic [31:0] v);
      ld_en = 1'b1; ld_idx = i; ld_data = v;
      tick();
      ld_en = 1'b0;
      mdl[i] = v;
   endtask

   task automatic fetch(input string tag, input logic [63:0] a, input logic [31:0] ed,
                        input logic ee, input int hold, input bit early,
                        input bit ld, input logic [IW-1:0] li, input logic [31:0] ldat);
      req_valid = 1'b1;
      req_addr  = a;
      chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
      if (ld) begin
         ld_en = 1'b1; ld_idx = li; ld_data = ldat;
      end
      tick();
      req_valid = 1'b0;
      req_addr  = {$urandom, $urandom};
      ld_en     = 1'b0;
      if (ld) mdl[li] = ldat;
      if (early) resp_ready = 1'b1;
      for (int n = 1; n < LAT; n++) begin
         chk({tag, " valid early"}, 64'(resp_valid), 64'd0);
         chk({tag, " ready busy"}, 64'(req_ready), 64'd0);
         tick();
      end
      chk({tag, " valid"}, 64'(resp_valid), 64'd1);
      chk({tag, " data"}, 64'(resp_data), 64'(ed));
      chk({tag, " err"}, 64'(resp_err), 64'(ee));
      chk({tag, " ready resp"}, 64'(req_ready), 64'd0);
      if (!early) begin
         for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, " hold valid"}, 64'(resp_valid), 64'd1);
            chk({tag, " hold data"}, 64'(resp_data), 64'(ed));
            chk({tag, " hold err"}, 64'(resp_err), 64'(ee));
            chk({tag, " hold ready"}, 64'(req_ready), 64'd0);
         end
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk({tag, " valid after hs"}, 64'(resp_valid), 64'd0);
      chk({tag, " ready after hs"}, 64'(req_ready), 64'd1);
      $display("fetch %s addr=%h exp_data=%h exp_err=%0d hold=%0d", tag, a, ed, ee, hold);
   endtask

   initial begin
      logic [63:0] a;
      logic [31:0] ed;
      logic        ee;
      int          r;

      rst = 1'b0; req_valid = 1'b0; req_addr = 64'd0; resp_ready = 1'b0;
      ld_en = 1'b0; ld_idx = '0; ld_data = 32'd0;

      // Reset state, with the initial image loaded while reset is held.
      tick();
      tick();
      chk("rst req_ready", 64'(req_ready), 64'd0);
      chk("rst resp_valid", 64'(resp_valid), 64'd0);
      chk("rst resp_data", 64'(resp_data), 64'd0);
      chk("rst resp_err", 64'(resp_err), 64'd0);
      load(12'd0, 32'h0000_0413);
      load(12'd1, 32'h0010_0513);
      for (int i = 2; i < 64; i++) load(12'(i), $urandom);
      load(12'(MW - 1), 32'hCAFE_0001);
      chk("rst req_ready hold", 64'(req_ready), 64'd0);
      rst = 1'b1;
      tick();
      chk("release req_ready", 64'(req_ready), 64'd1);
      chk("release resp_valid", 64'(resp_valid), 64'd0);

      vecs[0] = '{BASE,                        32'h0000_0413, 1'b0, 0};
      vecs[1] = '{BASE + 64'd4,                32'h0010_0513, 1'b0, 0};
      vecs[2] = '{BASE,                        32'h0000_0413, 1'b0, 5};
      vecs[3] = '{BASE + 64'd2,                32'd0,         1'b1, 0};
      vecs[4] = '{64'h7FFF_FFFC,               32'd0,         1'b1, 2};
      vecs[5] = '{BASE + 64'(4 * MW),          32'd0,         1'b1, 0};
      vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFC,     32'd0,         1'b1, 0};
      vecs[7] = '{BASE + 64'(4 * (MW - 1)),    32'hCAFE_0001, 1'b0, 0};
      vecs[8] = '{BASE + 64'd1,                32'd0,         1'b1, 0};
      vecs[9] = '{64'd0,                       32'd0,         1'b1, 0};
      for (int i = 0; i < 10; i++)
         fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].d, vecs[i].e, vecs[i].hold,
               1'b0, 1'b0, '0, 32'd0);

      // Back-to-back with resp_ready held high from acceptance.
      fetch("b2b0", BASE, 32'h0000_0413, 1'b0, 0, 1'b1, 1'b0, '0, 32'd0);
      fetch("b2b1", BASE + 64'd4, 32'h0010_0513, 1'b0, 0, 1'b1, 1'b0, '0, 32'd0);

      // Same-edge load returns the old word; the next fetch sees the new one.
      fetch("rbw_old", BASE + 64'd4, 32'h0010_0513, 1'b0, 0, 1'b0, 1'b1, 12'd1, 32'hDEAD_BEEF);
      fetch("rbw_new", BASE + 64'd4, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1'b0, '0, 32'd0);

      // Reset while in WAIT, with a load issued during reset.
      req_valid = 1'b1; req_addr = BASE;
      tick();
      req_valid = 1'b0;
      chk("wrst in wait", 64'(resp_valid), 64'd0);
      rst = 1'b0; ld_en = 1'b1; ld_idx = 12'd5; ld_data = 32'h5A5A_0005;
      tick();
      rst = 1'b1; ld_en = 1'b0; mdl[5] = 32'h5A5A_0005;
      chk("wrst ready", 64'(req_ready), 64'd0);
      chk("wrst valid", 64'(resp_valid), 64'd0);
      chk("wrst data", 64'(resp_data), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("wrst post ready", 64'(req_ready), 64'd1);
         chk("wrst post valid", 64'(resp_valid), 64'd0);
      end
      $display("reset in WAIT done");
      fetch("wrst mem0", BASE, 32'h0000_0413, 1'b0, 0, 1'b0, 1'b0, '0, 32'd0);
      fetch("wrst mem5", BASE + 64'd20, 32'h5A5A_0005, 1'b0, 0, 1'b0, 1'b0, '0, 32'd0);

      // Reset while the response is being held.
      req_valid = 1'b1; req_addr = BASE + 64'd4;
      tick();
      req_valid = 1'b0;
      for (int n = 1; n < LAT; n++) tick();
      chk("rrst in resp", 64'(resp_valid), 64'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("rrst valid", 64'(resp_valid), 64'd0);
      chk("rrst ready", 64'(req_ready), 64'd0);
      tick();
      chk("rrst post valid", 64'(resp_valid), 64'd0);
      chk("rrst post ready", 64'(req_ready), 64'd1);
      $display("reset in RESP done");

      // Randomized fetches with optional same-edge loads.
      for (int t = 0; t < 150; t++) begin
         logic [IW-1:0] li;
         logic [31:0]   ldat;
         bit            ld, early;
         int            hold;
         r  = $urandom_range(0, 9);
         li = 12'($urandom_range(0, 63));
         if (r < 6)       a = BASE + 64'(4 * $urandom_range(0, 63));
         else if (r == 6) a = BASE + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
         else if (r == 7) a = BASE - 64'(4 * $urandom_range(1, 1000));
         else if (r == 8) a = BASE + 64'(4 * MW) + 64'(4 * $urandom_range(0, 1000));
         else             a = {32'hFFFF_FFFF, $urandom} & ~64'd3;
         ref_fetch(a, ed, ee);
         ld    = ($urandom_range(0, 1) == 1);
         ldat  = $urandom;
         early = ($urandom_range(0, 2) == 0);
         hold  = early ? 0 : $urandom_range(0, 3);
         fetch($sformatf("rnd%0d", t), a, ed, ee, hold, early, ld, li, ldat);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
